legv8_fetch_unit: RTL and testbench

Instruction-fetch front end for the LEGv8 core. Owns the fetch PC, issues 32-bit instruction reads to instruction memory (at most one outstanding), buffers returned words in a small FIFO, and presents them to decode over a valid/ready handshake. It accepts branch/exception redirects from the execute stage, flushing buffered and in-flight instructions.

---
 rtl/legv8_fetch_unit.sv | 87 ++++++++
 tb/tb_legv8_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_fetch_unit.sv
// legv8_fetch_unit: LEGv8 fetch front end, single outstanding imem read feeding a decode queue
module legv8_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_restart_cpu,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_if_valid,
  output logic [31:0]       o_if_instr,
  output logic [ADDR_W-1:0] o_if_pc,
  input  logic              i_if_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [ADDR_W-1:0] r_pc_mem [DEPTH];
  logic [31:0]       r_instr_mem [DEPTH];
  logic [CW:0]       w_occ;
  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_issue;
  logic              w_enq;
  logic              w_deq;
  // The outstanding request reserves a slot, so a full queue can never be overrun.
  assign w_occ      = {1'b0, r_cnt} + {{CW{1'b0}}, r_state == BUSY};
  assign w_issue    = !i_restart_cpu && !i_redirect_valid &&
                      (r_state == IDLE || (r_state == BUSY && i_imem_ack)) &&
                      (w_occ < (CW+1)'(DEPTH));
  assign w_enq      = r_state == BUSY && i_imem_ack && !i_redirect_valid;
  assign w_deq      = o_if_valid && i_if_ready && !i_redirect_valid;
  assign w_redir_pc = i_redirect_pc & ~ADDR_W'(3);
  assign o_imem_req  = w_issue;
  assign o_imem_addr = r_fetch_pc;
  assign o_if_valid  = r_cnt != '0;
  assign o_if_instr  = r_instr_mem[r_rp];
  assign o_if_pc     = r_pc_mem[r_rp];
  // Queue storage: returned words tagged with the address they were fetched from.
  always_ff @(posedge i_clk or posedge i_restart_cpu) begin
    if (i_restart_cpu) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (w_enq) begin
      r_pc_mem[r_wp]    <= r_req_pc;
      r_instr_mem[r_wp] <= i_imem_rdata;
    end
  end
  // Fetch FSM, PC and queue pointers; a redirect flushes everything and may leave a read to drop.
  always_ff @(posedge i_clk or posedge i_restart_cpu) begin
    if (i_restart_cpu) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_cnt      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else if (i_redirect_valid) begin
      r_state    <= (r_state != IDLE && !i_imem_ack) ? DISCARD : IDLE;
      r_fetch_pc <= w_redir_pc;
      r_cnt      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      r_state <= w_issue ? BUSY : (r_state != IDLE && i_imem_ack) ? IDLE : r_state;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        r_req_pc   <= r_fetch_pc;
      end
      if (w_enq) r_wp <= r_wp + PW'(1);
      if (w_deq) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
    end
  end
endmodule

// File: tb/tb_legv8_fetch_unit.sv
// tb_legv8_fetch_unit: scenario tasks plus a randomized run against a sequential-PC stream model
module tb_legv8_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        redir;
  logic [63:0] rpc;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        mem_auto;
  logic        rand_lat;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        pend;
  logic [63:0] paddr;
  int          lat_left;
  logic        ack;
  logic [31:0] rdata;
  logic        req;
  logic [63:0] addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  int          checks = 0;
  int          errors = 0;

  assign ack   = mem_auto ? a_ack : m_ack;
  assign rdata = mem_auto ? a_rdata : m_rdata;

  always #5 clk = ~clk;

  legv8_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .DEPTH(4)) dut (
    .i_clk(clk), .i_restart_cpu(rst), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata), .i_redirect_valid(redir), .i_redirect_pc(rpc),
    .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc), .i_if_ready(ready)
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Behavioural instruction memory: answers each request after a fixed or random latency.
  initial begin
    a_ack = 1'b0; a_rdata = '0; pend = 1'b0; paddr = '0; lat_left = 0;
    forever begin
      @(posedge clk); #1;
      a_ack = 1'b0;
      if (!mem_auto) pend = 1'b0;
      else if (pend) begin
        if (lat_left <= 1) begin a_ack = 1'b1; a_rdata = word_of(paddr); pend = 1'b0; end
        else lat_left--;
      end
      @(negedge clk);
      if (mem_auto && req) begin
        pend = 1'b1; paddr = addr;
        lat_left = rand_lat ? int'($urandom_range(1, 5)) : 1;
      end
    end
  end

  task automatic do_reset(input logic auto_mem, input logic slow);
    @(posedge clk); #1;
    rst = 1'b1; mem_auto = auto_mem; rand_lat = slow; ready = 1'b0; redir = 1'b0; m_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drv(input logic a, input logic [31:0] d, input logic rv, input logic [63:0] p);
    @(posedge clk); #1;
    m_ack = a; m_rdata = d; redir = rv; rpc = p;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", req); end
    checks++; if (addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", if_valid); end
    checks++; if (if_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_instr); end
    @(posedge clk); #1;
    ready = 1'b1; rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [63:0] e;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e = 64'(4 * k);
      checks++;
      if (req !== 1'b1 || addr !== e) begin
        errors++; $display("FAIL stream_req k=%0d got req=%0b addr=%h exp req=1 addr=%h", k, req, addr, e);
      end
      if (k >= 2) begin
        e = 64'(4 * (k - 2));
        checks++;
        if (if_valid !== 1'b1 || if_pc !== e || if_instr !== word_of(e)) begin
          errors++; $display("FAIL stream_out k=%0d got v=%0b pc=%h ins=%h exp v=1 pc=%h ins=%h", k, if_valid, if_pc, if_instr, e, word_of(e));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] q[$];
    logic [63:0] pops[$];
    logic [63:0] first;
    logic got;
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req) q.push_back(addr);
      @(posedge clk); #1;
    end
    checks++; if (q.size() != 4) begin errors++; $display("FAIL bp_nreq got %0d exp 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q.size() || q[i] !== 64'(4 * i)) begin errors++; $display("FAIL bp_addr%0d got %h exp %h", i, (i < q.size()) ? q[i] : 64'hx, 64'(4 * i)); end
    end
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h0 || req !== 1'b0) begin
      errors++; $display("FAIL bp_hold got v=%0b pc=%h req=%0b exp v=1 pc=0 req=0", if_valid, if_pc, req);
    end
    @(posedge clk); #1;
    ready = 1'b1; got = 1'b0; first = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_valid && ready) pops.push_back(if_pc);
      if (req && !got) begin got = 1'b1; first = addr; end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= pops.size() || pops[i] !== 64'(4 * i)) begin errors++; $display("FAIL bp_drain%0d got %h exp %h", i, (i < pops.size()) ? pops[i] : 64'hx, 64'(4 * i)); end
    end
    checks++;
    if (!got || first !== 64'h10) begin errors++; $display("FAIL bp_resume got seen=%0b addr=%h exp addr=10", got, first); end
  endtask

  task automatic test_redirect_late();
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 64'h0) begin errors++; $display("FAIL rl_req0 got req=%0b addr=%h exp 1/0", req, addr); end
    drv(1'b1, word_of(64'h0), 1'b0, '0);
    drv(1'b1, word_of(64'h4), 1'b0, '0);
    checks++; if (req !== 1'b1 || addr !== 64'h8) begin errors++; $display("FAIL rl_req8 got req=%0b addr=%h exp 1/8", req, addr); end
    drv(1'b0, '0, 1'b1, 64'h1003);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rl_redir_req got %0b exp 0", req); end
    drv(1'b0, '0, 1'b0, '0);
    checks++; if (if_valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL rl_flush got v=%0b req=%0b exp 0/0", if_valid, req); end
    drv(1'b0, '0, 1'b0, '0);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rl_wait got req=%0b exp 0", req); end
    drv(1'b1, 32'hBAD0_BAD0, 1'b0, '0);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rl_drop_req got %0b exp 0", req); end
    drv(1'b0, '0, 1'b0, '0);
    checks++; if (req !== 1'b1 || addr !== 64'h1000) begin errors++; $display("FAIL rl_newreq got req=%0b addr=%h exp 1/1000", req, addr); end
    drv(1'b1, word_of(64'h1000), 1'b0, '0);
    drv(1'b0, '0, 1'b0, '0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h1000 || if_instr !== word_of(64'h1000)) begin
      errors++; $display("FAIL rl_out got v=%0b pc=%h ins=%h exp 1/1000/%h", if_valid, if_pc, if_instr, word_of(64'h1000));
    end
  endtask

  task automatic test_redirect_ack();
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    drv(1'b1, word_of(64'h0), 1'b0, '0);
    checks++; if (req !== 1'b1 || addr !== 64'h4) begin errors++; $display("FAIL ra_req4 got req=%0b addr=%h exp 1/4", req, addr); end
    drv(1'b1, word_of(64'h4), 1'b1, 64'h2000);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL ra_redir_req got %0b exp 0", req); end
    drv(1'b0, '0, 1'b0, '0);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ra_flush got v=%0b exp 0", if_valid); end
    checks++; if (req !== 1'b1 || addr !== 64'h2000) begin errors++; $display("FAIL ra_newreq got req=%0b addr=%h exp 1/2000", req, addr); end
    drv(1'b1, word_of(64'h2000), 1'b0, '0);
    drv(1'b0, '0, 1'b0, '0);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h2000) begin errors++; $display("FAIL ra_out got v=%0b pc=%h exp 1/2000", if_valid, if_pc); end
  endtask

  task automatic test_restart_mid();
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    drv(1'b1, word_of(64'h0), 1'b0, '0);
    drv(1'b1, word_of(64'h4), 1'b0, '0);
    drv(1'b1, word_of(64'h8), 1'b0, '0);
    drv(1'b0, '0, 1'b0, '0);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h0) begin errors++; $display("FAIL rm_pre got v=%0b pc=%h exp 1/0", if_valid, if_pc); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 64'h0 || if_instr !== 32'h0 || req !== 1'b0 || addr !== 64'h0) begin
      errors++; $display("FAIL rm_async got v=%0b pc=%h ins=%h req=%0b addr=%h exp all 0", if_valid, if_pc, if_instr, req, addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; m_ack = 1'b1; m_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 64'h0) begin errors++; $display("FAIL rm_req got req=%0b addr=%h exp 1/0", req, addr); end
    drv(1'b1, word_of(64'h0), 1'b0, '0);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rm_stale got v=%0b ins=%h exp v=0", if_valid, if_instr); end
    drv(1'b0, '0, 1'b0, '0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h0 || if_instr !== word_of(64'h0)) begin
      errors++; $display("FAIL rm_out got v=%0b pc=%h ins=%h exp 1/0/%h", if_valid, if_pc, if_instr, word_of(64'h0));
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_pc;
    int outst;
    int pops;
    logic chk_empty;
    do_reset(1'b1, 1'b1);
    exp_pc = 64'h0; outst = 0; pops = 0; chk_empty = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      ready = $urandom_range(0, 3) != 0;
      redir = $urandom_range(0, 19) == 0;
      rpc = {$urandom, $urandom};
      @(negedge clk);
      if (chk_empty) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush k=%0d got v=%0b exp 0", k, if_valid); end
        chk_empty = 1'b0;
      end
      outst = outst - int'(ack) + int'(req);
      checks++; if (outst > 1 || outst < 0) begin errors++; $display("FAIL rnd_outstanding k=%0d got %0d exp 0..1", k, outst); end
      if (redir) begin
        exp_pc = rpc & ~64'h3;
        chk_empty = 1'b1;
      end else if (if_valid && ready) begin
        checks++;
        if (if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
          errors++; $display("FAIL rnd_stream k=%0d got pc=%h ins=%h exp pc=%h ins=%h", k, if_pc, if_instr, exp_pc, word_of(exp_pc));
        end
        exp_pc = exp_pc + 64'h4;
        pops++;
      end
      @(posedge clk); #1;
    end
    redir = 1'b0;
    checks++; if (pops < 50) begin errors++; $display("FAIL rnd_progress got %0d pops exp >=50", pops); end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; redir = 1'b0; rpc = '0; m_ack = 1'b0; m_rdata = '0;
    mem_auto = 1'b1; rand_lat = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_late();
    test_redirect_ack();
    test_restart_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
